// File: rtl/scr1_imem_sram_resp.sv
// Instruction-memory responder: serves IMEM fetch requests from a single-port
// synchronous SRAM (one-cycle read latency) with optional wait states.
package scr1_memif_pkg;
    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_IMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_imem_sram_resp
    import scr1_memif_pkg::*;
#(
    parameter int SCR1_MEM_AWIDTH  = 14,
    parameter int SCR1_WAIT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_ack,
    input  logic                        imem_req,
    input  type_scr1_mem_cmd_e          imem_cmd,
    input  logic [SCR1_IMEM_AWIDTH-1:0] imem_addr,
    output logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata,
    output type_scr1_mem_resp_e         imem_resp,
    output logic                        sram_ce,
    output logic [SCR1_MEM_AWIDTH-1:0]  sram_addr,
    input  logic [31:0]                 sram_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(SCR1_WAIT_CYCLES);
    localparam bit         NO_WAIT   = (SCR1_WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Non-read commands, misaligned or out-of-range addresses never reach SRAM.
    function automatic logic req_err(input type_scr1_mem_cmd_e cmd,
                                     input logic [SCR1_IMEM_AWIDTH-1:0] addr);
        logic [SCR1_IMEM_AWIDTH-1:0] hi_mask;
        hi_mask = {SCR1_IMEM_AWIDTH{1'b1}} << (SCR1_MEM_AWIDTH + 2);
        return (cmd != SCR1_MEM_CMD_RD) | (addr[1:0] != 2'b00) | (|(addr & hi_mask));
    endfunction

    state_e      state_r;
    state_e      state_nxt_s;
    state_e      state_acc_s;
    logic [3:0]  wcnt_r;
    logic        err_r;
    logic [31:0] data_r;
    logic        rd_pend_r;
    logic        req_ack_s;
    logic        accept_s;
    logic        err_s;

    // Acceptance decode shared by the FSM, datapath and outputs.
    always_comb begin
        req_ack_s = 1'b0;
        case (state_r)
            ST_IDLE: req_ack_s = 1'b1;
            ST_RESP: req_ack_s = ~err_r;
            default: req_ack_s = 1'b0;
        endcase
        accept_s    = rst_n & imem_req & req_ack_s;
        err_s       = req_err(imem_cmd, imem_addr);
        state_acc_s = NO_WAIT ? ST_RESP : ST_WAIT;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = state_acc_s;
                else          state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (wcnt_r == 4'd1) state_nxt_s = ST_RESP;
                else                state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (accept_s) state_nxt_s = state_acc_s;
                else          state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Wait counter, error flag and captured read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_r    <= 4'd0;
            err_r     <= 1'b0;
            data_r    <= 32'd0;
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= sram_ce;
            if (rd_pend_r) begin
                data_r <= sram_rdata;
            end
            if (accept_s) begin
                err_r  <= err_s;
                wcnt_r <= WAIT_INIT;
            end else if (state_r == ST_WAIT) begin
                wcnt_r <= wcnt_r - 4'd1;
            end
        end
    end

    // Outputs; held at reset values while rst_n is low so no response escapes.
    always_comb begin
        imem_req_ack = 1'b1;
        imem_resp    = SCR1_MEM_RESP_NOTRDY;
        imem_rdata   = {SCR1_IMEM_DWIDTH{1'b0}};
        sram_ce      = 1'b0;
        sram_addr    = imem_addr[SCR1_MEM_AWIDTH+1:2];
        if (!rst_n) begin
            imem_req_ack = 1'b1;
        end else begin
            imem_req_ack = req_ack_s;
            sram_ce      = accept_s & ~err_s;
            case (state_r)
                ST_RESP: begin
                    if (err_r) begin
                        imem_resp  = SCR1_MEM_RESP_RDY_ER;
                        imem_rdata = {SCR1_IMEM_DWIDTH{1'b0}};
                    end else begin
                        imem_resp  = SCR1_MEM_RESP_RDY_OK;
                        imem_rdata = NO_WAIT ? sram_rdata : data_r;
                    end
                end
                default: begin
                    imem_resp  = SCR1_MEM_RESP_NOTRDY;
                    imem_rdata = {SCR1_IMEM_DWIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule
